// File: rtl/stream_pkg.sv
// Shared definitions for the camera/SA stream mux and demux pair.
package stream_pkg;

    localparam int STREAM_DATA_W = 16;
    localparam int STREAM_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SA_HOLD = 2'd1,
        CAM_HI  = 2'd2,
        CAM_LO  = 2'd3
    } demux_state_t;

endpackage

// File: rtl/stream_width_down.sv
// Word-to-byte serializer: selects the byte for the current camera phase and places tlast on the second byte.
// Purely combinational over registered inputs; phase advance and backpressure live in the parent FSM.
module stream_width_down
    import stream_pkg::*;
#(
    parameter int DATA_W    = STREAM_DATA_W,
    parameter int BYTE_W    = STREAM_BYTE_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_last,
    input  logic              i_hi_phase,
    input  logic              i_lo_phase,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_last
);

    logic [BYTE_W-1:0] w_upper;
    logic [BYTE_W-1:0] w_lower;
    logic [BYTE_W-1:0] w_first;
    logic [BYTE_W-1:0] w_second;

    assign w_upper  = i_word[DATA_W-1 -: BYTE_W];
    assign w_lower  = i_word[BYTE_W-1:0];
    assign w_first  = MSB_FIRST ? w_upper : w_lower;
    assign w_second = MSB_FIRST ? w_lower : w_upper;

    // Outside the high phase the second byte is shown, so the bus holds its last value when idle.
    assign o_byte = i_hi_phase ? w_first : w_second;
    assign o_last = i_lo_phase & i_last;

endmodule

// File: rtl/stream_demux.sv
// Routes 16-bit packets to the SA sink (1 word/clk) or the camera sink (2 bytes/word); route frozen per packet.
// One clock from input accept to output valid; s_tready follows the active sink's tready when its beat completes.
module stream_demux
    import stream_pkg::*;
#(
    parameter int DATA_W    = STREAM_DATA_W,
    parameter int BYTE_W    = STREAM_BYTE_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              cam_tvalid,
    input  logic              cam_tready,
    output logic [BYTE_W-1:0] cam_tdata,
    output logic              cam_tlast,
    output logic              sa_tvalid,
    input  logic              sa_tready,
    output logic [DATA_W-1:0] sa_tdata,
    output logic              sa_tlast,
    output logic              busy
);

    demux_state_t      r_state;
    logic              r_in_pkt;
    logic              r_sel;
    logic [DATA_W-1:0] r_sa_dat;
    logic              r_sa_last;
    logic [DATA_W-1:0] r_cam_word;
    logic              r_cam_last;

    logic w_rdy;
    logic w_acc;
    logic w_route_sa;
    logic w_hi_phase;
    logic w_lo_phase;

    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            IDLE:    w_rdy = 1'b1;
            SA_HOLD: w_rdy = sa_tready;
            CAM_HI:  w_rdy = 1'b0;
            CAM_LO:  w_rdy = cam_tready;
            default: w_rdy = 1'b0;
        endcase
    end

    assign s_tready   = w_rdy & ~rst;
    assign w_acc      = s_tvalid & s_tready;
    assign w_route_sa = r_in_pkt ? r_sel : en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_pkt   <= 1'b0;
            r_sel      <= 1'b0;
            r_sa_dat   <= '0;
            r_sa_last  <= 1'b0;
            r_cam_word <= '0;
            r_cam_last <= 1'b0;
        end else if (w_acc) begin
            if (!r_in_pkt) begin
                r_sel <= en;
            end
            r_in_pkt <= ~s_tlast;
            if (w_route_sa) begin
                r_sa_dat  <= s_tdata;
                r_sa_last <= s_tlast;
                r_state   <= SA_HOLD;
            end else begin
                r_cam_word <= s_tdata;
                r_cam_last <= s_tlast;
                r_state    <= CAM_HI;
            end
        end else begin
            case (r_state)
                SA_HOLD: if (sa_tready)  r_state <= IDLE;
                CAM_HI:  if (cam_tready) r_state <= CAM_LO;
                CAM_LO:  if (cam_tready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_hi_phase = (r_state == CAM_HI);
    assign w_lo_phase = (r_state == CAM_LO);

    stream_width_down #(
        .DATA_W    (DATA_W),
        .BYTE_W    (BYTE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_width_down (
        .i_word     (r_cam_word),
        .i_last     (r_cam_last),
        .i_hi_phase (w_hi_phase),
        .i_lo_phase (w_lo_phase),
        .o_byte     (cam_tdata),
        .o_last     (cam_tlast)
    );

    assign cam_tvalid = w_hi_phase | w_lo_phase;
    assign sa_tvalid  = (r_state == SA_HOLD);
    assign sa_tdata   = r_sa_dat;
    assign sa_tlast   = r_sa_last & sa_tvalid;
    assign busy       = r_in_pkt | (r_state != IDLE);

endmodule

// File: tb/tb_stream_demux.sv
// Directed vector table, reset-in-flight sequence and a randomised scoreboard run for stream_demux.
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] s_tdata;
    logic        s_tlast;
    logic        cam_tvalid;
    logic        cam_tready;
    logic [7:0]  cam_tdata;
    logic        cam_tlast;
    logic        sa_tvalid;
    logic        sa_tready;
    logic [15:0] sa_tdata;
    logic        sa_tlast;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_demux dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .cam_tvalid (cam_tvalid),
        .cam_tready (cam_tready),
        .cam_tdata  (cam_tdata),
        .cam_tlast  (cam_tlast),
        .sa_tvalid  (sa_tvalid),
        .sa_tready  (sa_tready),
        .sa_tdata   (sa_tdata),
        .sa_tlast   (sa_tlast),
        .busy       (busy)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] dat;
        logic        last;
        logic        crdy;
        logic        srdy;
        logic [29:0] exp;
    } vec_t;

    typedef struct packed { logic [15:0] d; logic l; } sa_item_t;
    typedef struct packed { logic [7:0]  d; logic l; } cam_item_t;

    vec_t      vecs[26];
    sa_item_t  sa_q[$];
    cam_item_t cam_q[$];

    // Expected bundle: {s_tready, sa_tvalid, sa_tdata, sa_tlast, cam_tvalid, cam_tdata, cam_tlast, busy}
    function automatic vec_t mk(input logic i_en, i_vld, input logic [15:0] i_dat,
                                input logic i_last, i_crdy, i_srdy, e_rdy, e_sav,
                                input logic [15:0] e_sad, input logic e_sal, e_cv,
                                input logic [7:0] e_cd, input logic e_cl, e_busy);
        vec_t v;
        v.en   = i_en;
        v.vld  = i_vld;
        v.dat  = i_dat;
        v.last = i_last;
        v.crdy = i_crdy;
        v.srdy = i_srdy;
        v.exp  = {e_rdy, e_sav, e_sad, e_sal, e_cv, e_cd, e_cl, e_busy};
        return v;
    endfunction

    function automatic logic [29:0] outs();
        return {s_tready, sa_tvalid, sa_tdata, sa_tlast, cam_tvalid, cam_tdata, cam_tlast, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] cur_dat;
        logic        cur_last;
        bit          have;
        bit          m_in_pkt;
        bit          m_sel;
        bit          route_sa;
        int          beats_left;
        int          pkts_sent;
        int          cycles;
        sa_item_t    sa_exp;
        cam_item_t   cam_exp;

        //              en vld dat      last crdy srdy | rdy sav sad     sal cv cd     cl busy
        vecs[0]  = mk(1, 1, 16'h00FF, 0, 1, 1,   1, 0, 16'h0000, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 1, 16'hE0FF, 1, 1, 1,   1, 1, 16'h00FF, 0, 0, 8'h00, 0, 1);
        vecs[2]  = mk(1, 0, 16'h0000, 0, 1, 1,   1, 1, 16'hE0FF, 1, 0, 8'h00, 0, 1);
        vecs[3]  = mk(0, 1, 16'hE0A5, 1, 1, 1,   1, 0, 16'hE0FF, 0, 0, 8'h00, 0, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 1, 1,   0, 0, 16'hE0FF, 0, 1, 8'hE0, 0, 1);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 1, 1,   1, 0, 16'hE0FF, 0, 1, 8'hA5, 1, 1);
        vecs[6]  = mk(1, 1, 16'h1234, 0, 1, 1,   1, 0, 16'hE0FF, 0, 0, 8'hA5, 0, 0);
        vecs[7]  = mk(0, 1, 16'h5678, 1, 1, 1,   1, 1, 16'h1234, 0, 0, 8'hA5, 0, 1);
        vecs[8]  = mk(0, 1, 16'hABCD, 1, 1, 1,   1, 1, 16'h5678, 1, 0, 8'hA5, 0, 1);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 1, 1,   0, 0, 16'h5678, 0, 1, 8'hAB, 0, 1);
        vecs[10] = mk(0, 0, 16'h0000, 0, 1, 1,   1, 0, 16'h5678, 0, 1, 8'hCD, 1, 1);
        vecs[11] = mk(1, 1, 16'hBEEF, 1, 1, 0,   1, 0, 16'h5678, 0, 0, 8'hCD, 0, 0);
        vecs[12] = mk(1, 1, 16'hCAFE, 1, 1, 0,   0, 1, 16'hBEEF, 1, 0, 8'hCD, 0, 1);
        vecs[13] = mk(1, 1, 16'hCAFE, 1, 1, 0,   0, 1, 16'hBEEF, 1, 0, 8'hCD, 0, 1);
        vecs[14] = mk(1, 1, 16'hCAFE, 1, 1, 0,   0, 1, 16'hBEEF, 1, 0, 8'hCD, 0, 1);
        vecs[15] = mk(1, 1, 16'hCAFE, 1, 1, 1,   1, 1, 16'hBEEF, 1, 0, 8'hCD, 0, 1);
        vecs[16] = mk(1, 0, 16'h0000, 0, 1, 1,   1, 1, 16'hCAFE, 1, 0, 8'hCD, 0, 1);
        vecs[17] = mk(1, 0, 16'h0000, 0, 1, 1,   1, 0, 16'hCAFE, 0, 0, 8'hCD, 0, 0);
        vecs[18] = mk(0, 1, 16'h1357, 0, 0, 1,   1, 0, 16'hCAFE, 0, 0, 8'hCD, 0, 0);
        vecs[19] = mk(1, 1, 16'h2468, 1, 0, 1,   0, 0, 16'hCAFE, 0, 1, 8'h13, 0, 1);
        vecs[20] = mk(1, 1, 16'h2468, 1, 1, 1,   0, 0, 16'hCAFE, 0, 1, 8'h13, 0, 1);
        vecs[21] = mk(1, 1, 16'h2468, 1, 0, 1,   0, 0, 16'hCAFE, 0, 1, 8'h57, 0, 1);
        vecs[22] = mk(1, 1, 16'h2468, 1, 1, 1,   1, 0, 16'hCAFE, 0, 1, 8'h57, 0, 1);
        vecs[23] = mk(1, 0, 16'h0000, 0, 1, 1,   0, 0, 16'hCAFE, 0, 1, 8'h24, 0, 1);
        vecs[24] = mk(1, 0, 16'h0000, 0, 1, 1,   1, 0, 16'hCAFE, 0, 1, 8'h68, 1, 1);
        vecs[25] = mk(1, 0, 16'h0000, 0, 1, 1,   1, 0, 16'hCAFE, 0, 0, 8'h68, 0, 0);

        rst        = 1'b1;
        en         = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        cam_tready = 1'b0;
        sa_tready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {2'b0, outs()}, 32'h0);
        rst = 1'b0;
        #1;
        chk("release_ready_busy", {30'b0, s_tready, busy}, 32'h2);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            en         = vecs[i].en;
            s_tvalid   = vecs[i].vld;
            s_tdata    = vecs[i].dat;
            s_tlast    = vecs[i].last;
            cam_tready = vecs[i].crdy;
            sa_tready  = vecs[i].srdy;
            #1;
            chk($sformatf("vec%0d", i), {2'b0, outs()}, {2'b0, vecs[i].exp});
        end

        // Reset asserted while a camera word sits in its first-byte phase.
        @(negedge clk);
        en = 1'b0; s_tvalid = 1'b1; s_tdata = 16'h9ABC; s_tlast = 1'b0; cam_tready = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        chk("pre_reset_cam_hi", {23'b0, cam_tvalid, cam_tdata}, {23'b0, 1'b1, 8'h9A});
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {2'b0, outs()}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_idle", {29'b0, s_tready, busy, cam_tvalid}, 32'h4);

        have       = 1'b0;
        m_in_pkt   = 1'b0;
        m_sel      = 1'b0;
        beats_left = 0;
        pkts_sent  = 0;
        cycles     = 0;
        cur_dat    = '0;
        cur_last   = 1'b0;
        while (!(pkts_sent == 200 && !have && sa_q.size() == 0 && cam_q.size() == 0)) begin
            if (cycles >= 20000) begin
                chk("random_timeout", 32'(cycles), 32'd0);
                break;
            end
            @(negedge clk);
            if (!have && pkts_sent < 200 && $urandom_range(0, 3) != 0) begin
                if (beats_left == 0) beats_left = $urandom_range(1, 4);
                cur_dat  = 16'($urandom);
                cur_last = (beats_left == 1);
                have     = 1'b1;
            end
            s_tvalid   = have;
            s_tdata    = cur_dat;
            s_tlast    = cur_last;
            en         = 1'($urandom_range(0, 1));
            sa_tready  = ($urandom_range(0, 3) != 0);
            cam_tready = ($urandom_range(0, 3) != 0);
            #1;
            if (s_tvalid && s_tready) begin
                route_sa = m_in_pkt ? m_sel : en;
                if (!m_in_pkt) m_sel = en;
                m_in_pkt = !cur_last;
                if (route_sa) begin
                    sa_q.push_back({cur_dat, cur_last});
                end else begin
                    cam_q.push_back({cur_dat[15:8], 1'b0});
                    cam_q.push_back({cur_dat[7:0], cur_last});
                end
                have = 1'b0;
                beats_left--;
                if (cur_last) pkts_sent++;
            end
            if (sa_tvalid && sa_tready) begin
                if (sa_q.size() == 0) begin
                    chk("sa_spurious", {15'b0, sa_tdata, sa_tlast}, 32'h1_0000_0);
                end else begin
                    sa_exp = sa_q.pop_front();
                    chk("sa_word", {15'b0, sa_tdata, sa_tlast}, {15'b0, sa_exp});
                end
            end
            if (cam_tvalid && cam_tready) begin
                if (cam_q.size() == 0) begin
                    chk("cam_spurious", {23'b0, cam_tdata, cam_tlast}, 32'h200);
                end else begin
                    cam_exp = cam_q.pop_front();
                    chk("cam_byte", {23'b0, cam_tdata, cam_tlast}, {23'b0, cam_exp});
                end
            end
            if (sa_tvalid || cam_tvalid) begin
                chk("single_sink_valid", {31'b0, sa_tvalid & cam_tvalid}, 32'h0);
            end
            cycles++;
        end
        s_tvalid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
